// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the load/store data port (D) and the
// instruction refill port (I). One requester is granted per cycle; the granted
// requester drives the memory in the same cycle, and read data is returned
// to the issuing port one cycle later.
//
// Build option:
//   ARB_RR_EN  defined   : contended cycles alternate winners (round-robin).
//              undefined : D wins contention unless I has been denied
//                          STARVE_MAX consecutive cycles (default build).
//
// Ports:
//   clk, Reset             clock, synchronous active-high reset
//   d_req/d_we/d_addr/d_wdata  data port request, write flag, address, data
//   d_gnt                  data port granted this cycle (combinational)
//   d_rvalid/d_rdata       data port read response
//   i_req/i_addr           refill request and address (reads only)
//   i_gnt                  refill granted this cycle (combinational)
//   i_rvalid/i_rdata       refill read response
//   mem_en/mem_we/mem_addr/mem_wdata  memory command for the granted port
//   mem_rdata              memory read data, one cycle after a read access
module mem_port_arbiter #(
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          Reset,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // instruction refill port
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  // shared memory
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D    = 2'd1,
    OWN_I    = 2'd2
  } owner_e;

  owner_e        rd_owner_q, rd_owner_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic          d_win, i_win;

`ifdef ARB_RR_EN
  // Only the round-robin build consumes the previous winner.
  logic          last_is_i_q, last_is_i_d;
`else
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
`endif

  // Arbitration: at most one winner, nothing granted while in reset.
  always_comb begin
    d_win = 1'b0;
    i_win = 1'b0;
    if (!Reset) begin
      if (d_req && i_req) begin
`ifdef ARB_RR_EN
        i_win = ~last_is_i_q;
`else
        i_win = (starve_cnt_q == SW'(STARVE_MAX));
`endif
        d_win = ~i_win;
      end else begin
        d_win = d_req;
        i_win = i_req;
      end
    end
  end

  assign d_gnt = d_win;
  assign i_gnt = i_win;

  // Memory command follows the winner; address/data hold when idle.
  always_comb begin
    mem_en    = d_win | i_win;
    mem_we    = d_win & d_we;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if (d_win) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_win) begin
      mem_addr  = i_addr;
    end
  end

  // Response valids are suppressed while reset is held so a read granted
  // just before reset never surfaces.
  assign d_rvalid = (rd_owner_q == OWN_D) & ~Reset;
  assign i_rvalid = (rd_owner_q == OWN_I) & ~Reset;

  // Read data passes straight through on the valid cycle, otherwise holds.
  assign d_rdata = d_rvalid ? mem_rdata : d_rdata_q;
  assign i_rdata = i_rvalid ? mem_rdata : i_rdata_q;

  // Next-state logic for all registered state.
  always_comb begin
    rd_owner_d  = OWN_NONE;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    d_rdata_d   = d_rdata;
    i_rdata_d   = i_rdata;

    if (d_win && !d_we) begin
      rd_owner_d = OWN_D;
    end else if (i_win) begin
      rd_owner_d = OWN_I;
    end

`ifdef ARB_RR_EN
    last_is_i_d = last_is_i_q;
    if (d_win) begin
      last_is_i_d = 1'b0;
    end else if (i_win) begin
      last_is_i_d = 1'b1;
    end
`else
    // Counts consecutive denied I cycles, saturating at STARVE_MAX.
    starve_cnt_d = '0;
    if (i_req && !i_win) begin
      if (starve_cnt_q == SW'(STARVE_MAX)) begin
        starve_cnt_d = starve_cnt_q;
      end else begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
    end
`endif
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      rd_owner_q   <= OWN_NONE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      d_rdata_q    <= '0;
      i_rdata_q    <= '0;
`ifdef ARB_RR_EN
      last_is_i_q  <= 1'b1;
`else
      starve_cnt_q <= '0;
`endif
    end else begin
      rd_owner_q   <= rd_owner_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      d_rdata_q    <= d_rdata_d;
      i_rdata_q    <= i_rdata_d;
`ifdef ARB_RR_EN
      last_is_i_q  <= last_is_i_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port RAM.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          Reset;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(3)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic prev_d, prev_i, exp_d, exp_i;

  initial begin
    for (int a = 0; a < 1024; a++) ram[a] = 32'hA500_0000 | 32'(a);
    ram[5] = 32'hDEAD_BEEF;
    mem_rdata = '0;
    Reset = 1'b1;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    i_req = 1'b0; i_addr = '0;

    // Reset state, with requests asserted to confirm nothing is granted.
    repeat (2) cyc();
    d_req = 1'b1; i_req = 1'b1; d_addr = 10'h3FF; i_addr = 10'h2AA;
    #1;
    check_eq("rst_d_gnt", 32'(d_gnt), 32'd0);
    check_eq("rst_i_gnt", 32'(i_gnt), 32'd0);
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check_eq("rst_i_rvalid", 32'(i_rvalid), 32'd0);

    // D read of 0x005.
    cyc();
    Reset = 1'b0; i_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h005;
    #1;
    check_eq("rd_d_gnt", 32'(d_gnt), 32'd1);
    check_eq("rd_i_gnt", 32'(i_gnt), 32'd0);
    check_eq("rd_mem_en", 32'(mem_en), 32'd1);
    check_eq("rd_mem_we", 32'(mem_we), 32'd0);
    check_eq("rd_mem_addr", 32'(mem_addr), 32'h005);
    cyc();
    d_req = 1'b0;
    #1;
    check_eq("rd_d_rvalid", 32'(d_rvalid), 32'd1);
    check_eq("rd_d_rdata", d_rdata, 32'hDEAD_BEEF);
    check_eq("rd_i_rvalid", 32'(i_rvalid), 32'd0);
    check_eq("idle_mem_en", 32'(mem_en), 32'd0);
    check_eq("idle_addr_hold", 32'(mem_addr), 32'h005);
    cyc();
    check_eq("rd_rvalid_1cyc", 32'(d_rvalid), 32'd0);
    check_eq("rd_rdata_hold", d_rdata, 32'hDEAD_BEEF);

    // D write of 0x010 then read back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h010; d_wdata = 32'h1234_5678;
    #1;
    check_eq("wr_d_gnt", 32'(d_gnt), 32'd1);
    check_eq("wr_mem_we", 32'(mem_we), 32'd1);
    check_eq("wr_mem_addr", 32'(mem_addr), 32'h010);
    check_eq("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    cyc();
    d_we = 1'b0; d_wdata = 32'h0;
    #1;
    check_eq("wr_no_rvalid", 32'(d_rvalid), 32'd0);
    check_eq("rb_d_gnt", 32'(d_gnt), 32'd1);
    cyc();
    d_req = 1'b0;
    #1;
    check_eq("rb_d_rvalid", 32'(d_rvalid), 32'd1);
    check_eq("rb_d_rdata", d_rdata, 32'h1234_5678);

    // Contention: both ports held high for 8 cycles.
    // Last winner before this is D, so round-robin starts with I.
    prev_d = 1'b0; prev_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      d_req = 1'b1; d_we = 1'b0; d_addr = 10'h005;
      i_req = 1'b1; i_addr = 10'h008;
`ifdef ARB_RR_EN
      exp_i = (k % 2 == 0);
`else
      exp_i = (k % 4 == 3);
`endif
      exp_d = ~exp_i;
      #1;
      check_eq($sformatf("arb_d_gnt_%0d", k), 32'(d_gnt), 32'(exp_d));
      check_eq($sformatf("arb_i_gnt_%0d", k), 32'(i_gnt), 32'(exp_i));
      check_eq($sformatf("arb_d_rvalid_%0d", k), 32'(d_rvalid), 32'(prev_d));
      check_eq($sformatf("arb_i_rvalid_%0d", k), 32'(i_rvalid), 32'(prev_i));
      if (prev_i) check_eq($sformatf("arb_i_rdata_%0d", k), i_rdata, 32'hA500_0008);
      if (prev_d) check_eq($sformatf("arb_d_rdata_%0d", k), d_rdata, 32'hDEAD_BEEF);
      prev_d = exp_d; prev_i = exp_i;
    end
    cyc();
    d_req = 1'b0; i_req = 1'b0;
    #1;
    check_eq("arb_tail_d_rvalid", 32'(d_rvalid), 32'(prev_d));
    check_eq("arb_tail_i_rvalid", 32'(i_rvalid), 32'(prev_i));
    check_eq("arb_tail_mem_en", 32'(mem_en), 32'd0);

    // I burst: 0x008..0x00F on consecutive cycles.
    for (int j = 0; j < 8; j++) begin
      cyc();
      i_req = 1'b1; i_addr = AW'(8 + j);
      #1;
      check_eq($sformatf("brst_i_gnt_%0d", j), 32'(i_gnt), 32'd1);
      check_eq($sformatf("brst_addr_%0d", j), 32'(mem_addr), 32'(8 + j));
      if (j > 0) begin
        check_eq($sformatf("brst_rvalid_%0d", j), 32'(i_rvalid), 32'd1);
        check_eq($sformatf("brst_rdata_%0d", j), i_rdata, 32'hA500_0000 | 32'(7 + j));
      end
    end
    cyc();
    i_req = 1'b0;
    #1;
    check_eq("brst_last_rvalid", 32'(i_rvalid), 32'd1);
    check_eq("brst_last_rdata", i_rdata, 32'hA500_000F);
    cyc();
    check_eq("brst_done_rvalid", 32'(i_rvalid), 32'd0);
    check_eq("brst_rdata_hold", i_rdata, 32'hA500_000F);

    // D read granted, then reset asserted before its response.
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h005;
    #1;
    check_eq("mrst_d_gnt", 32'(d_gnt), 32'd1);
    cyc();
    Reset = 1'b1;
    #1;
    check_eq("mrst_squash_rvalid", 32'(d_rvalid), 32'd0);
    check_eq("mrst_d_gnt_off", 32'(d_gnt), 32'd0);
    check_eq("mrst_mem_en_off", 32'(mem_en), 32'd0);
    cyc();
    check_eq("mrst_hold_rvalid", 32'(d_rvalid), 32'd0);
    check_eq("mrst_hold_gnt", 32'(d_gnt), 32'd0);
    check_eq("mrst_mem_addr", 32'(mem_addr), 32'd0);
    cyc();
    Reset = 1'b0;
    #1;
    check_eq("mrst_resume_gnt", 32'(d_gnt), 32'd1);
    check_eq("mrst_resume_rvalid0", 32'(d_rvalid), 32'd0);
    cyc();
    d_req = 1'b0;
    #1;
    check_eq("mrst_resume_rvalid", 32'(d_rvalid), 32'd1);
    check_eq("mrst_resume_rdata", d_rdata, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
